// File: rtl/scan_ctrl_sync_if.sv
// scan_ctrl_sync_if: pad-side scan pins, parallel status/config words and echo outputs
interface scan_ctrl_sync_if #(
  parameter int CHAIN_LEN = 64
);
  logic                 phi;
  logic                 phib;
  logic                 scan_i0o1;
  logic                 load;
  logic                 scan_in;
  logic [CHAIN_LEN-1:0] status_data;
  logic                 scan_out;
  logic [CHAIN_LEN-1:0] cfg_data;
  logic                 cfg_valid;
  logic                 seq_err;
  logic                 phi_out;
  logic                 phib_out;
  logic                 scan_i0o1_out;
  logic                 load_out;
  modport master (
    output phi, phib, scan_i0o1, load, scan_in, status_data,
    input  scan_out, cfg_data, cfg_valid, seq_err, phi_out, phib_out, scan_i0o1_out, load_out
  );
  modport slave (
    input  phi, phib, scan_i0o1, load, scan_in, status_data,
    output scan_out, cfg_data, cfg_valid, seq_err, phi_out, phib_out, scan_i0o1_out, load_out
  );
endinterface

// File: rtl/scan_ctrl_sync.sv
// scan_ctrl_sync: synchronised scan-chain front end with config commit and status shift-out
module scan_ctrl_sync #(
  parameter int CHAIN_LEN   = 64,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk_signal_ext,
  input logic             rst,
  scan_ctrl_sync_if.slave bus
);
  localparam int WARM = SYNC_STAGES + 1;
  localparam int CW   = $clog2(CHAIN_LEN + 1);
  localparam int WW   = $clog2(WARM + 1);
  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [4:0]                  pins, pin_s, hist, rise;
  logic [WW-1:0]               warm;
  logic [CHAIN_LEN-1:0]        shreg, shreg_n, cfg_q, cfg_n;
  logic [CW-1:0]               bit_cnt, cnt_n;
  logic                        out_q, out_n, valid_q, valid_n, err_q, err_n;
  logic                        phi_r, phib_r, load_r, mode, sin, overlap;
  assign pins    = {bus.scan_in, bus.load, bus.scan_i0o1, bus.phib, bus.phi};
  assign pin_s   = sync_q[SYNC_STAGES-1];
  assign rise    = (warm == WW'(WARM)) ? pin_s & ~hist : '0;
  assign phi_r   = rise[0];
  assign phib_r  = rise[1];
  assign mode    = pin_s[2];
  assign load_r  = rise[3];
  assign sin     = pin_s[4];
  // overlap is judged when a clock pin rises into it, so pins parked high through reset stay quiet
  assign overlap = pin_s[0] & pin_s[1] & (phi_r | phib_r);
  always_ff @(posedge clk_signal_ext) begin
    if (rst) begin
      sync_q <= '0;
      hist   <= '0;
      warm   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
      hist   <= pin_s;
      warm   <= (warm == WW'(WARM)) ? warm : warm + 1'b1;
    end
  end
  always_comb begin
    shreg_n = shreg;
    cnt_n   = bit_cnt;
    out_n   = out_q;
    cfg_n   = cfg_q;
    valid_n = 1'b0;
    err_n   = err_q | overlap;
    if (load_r) begin
      cnt_n = '0;
      err_n = err_n | phi_r;
      if (mode) begin
        shreg_n = bus.status_data;
        out_n   = bus.status_data[CHAIN_LEN-1];
      end else if (bit_cnt == CW'(CHAIN_LEN)) begin
        cfg_n   = shreg;
        valid_n = 1'b1;
      end else begin
        err_n = 1'b1;
      end
    end else begin
      if (phi_r) begin
        shreg_n = {shreg[CHAIN_LEN-2:0], sin};
        cnt_n   = (bit_cnt == CW'(CHAIN_LEN)) ? bit_cnt : bit_cnt + 1'b1;
      end
      if (phib_r) out_n = shreg_n[CHAIN_LEN-1];
    end
  end
  always_ff @(posedge clk_signal_ext) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      out_q   <= 1'b0;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shreg   <= shreg_n;
      bit_cnt <= cnt_n;
      out_q   <= out_n;
      cfg_q   <= cfg_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end
  assign bus.scan_out      = out_q;
  assign bus.cfg_data      = cfg_q;
  assign bus.cfg_valid     = valid_q;
  assign bus.seq_err       = err_q;
  assign bus.phi_out       = pin_s[0];
  assign bus.phib_out      = pin_s[1];
  assign bus.scan_i0o1_out = pin_s[2];
  assign bus.load_out      = pin_s[3];
endmodule
